// File: rtl/battle_pkg.sv
// Shared battle constants: move table, trainer encodings and HP width.
// Also used by the move display mux and the battle control FSM.
package battle_pkg;

  localparam int HP_W = 4;

  typedef logic [HP_W-1:0] hp_t;
  typedef logic [1:0]      move_idx_t;

  typedef enum logic {
    PLAYER = 1'b0,
    AI     = 1'b1
  } trainer_e;

  localparam logic [3:0] ACC_ALWAYS = 4'hF;

  // Packed so the table can be indexed directly by a move index; element 0 is the LSB slice.
  localparam logic [3:0][3:0] MOVE_DMG = {4'd12, 4'd8, 4'd5, 4'd3};
  localparam logic [3:0][3:0] MOVE_ACC = {4'd4, 4'd8, 4'd12, 4'd15};

  function automatic logic move_hits(input move_idx_t idx, input logic [3:0] roll);
    return (MOVE_ACC[idx] == ACC_ALWAYS) || (roll < MOVE_ACC[idx]);
  endfunction

  function automatic hp_t hp_sat_sub(input hp_t hp, input hp_t amount);
    return (hp > amount) ? hp_t'(hp - amount) : '0;
  endfunction

endpackage

// File: rtl/battle_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, feedback into bit 0.
module battle_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;
  logic       fb;

  assign fb  = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];
  assign q_d = {q_q[6:0], fb};
  assign q   = q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/battle_datapath.sv
// Battle datapath: holds both trainers' HP, resolves moves and applies damage.
// reset_n is expected to be released synchronously to clk by the reset source.
module battle_datapath
  import battle_pkg::*;
#(
  parameter int unsigned MAX_HP    = 15,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] p_move,
  input  logic       actr,
  input  logic       target,
  input  logic       calc_dmg,
  input  logic       app_dmg,
  output logic [3:0] p_hp,
  output logic [3:0] ai_hp,
  output logic [3:0] dmg,
  output logic       dmg_valid,
  output logic       last_hit,
  output logic [1:0] ai_move,
  output logic [7:0] rng
);

  localparam hp_t HP_INIT = hp_t'(MAX_HP);

  logic [7:0] rng_w;

  hp_t       p_hp_q, p_hp_d;
  hp_t       ai_hp_q, ai_hp_d;
  hp_t       dmg_q, dmg_d;
  logic      dmg_valid_q, dmg_valid_d;
  logic      last_hit_q, last_hit_d;
  move_idx_t ai_move_q, ai_move_d;

  trainer_e  actr_e;
  trainer_e  target_e;
  logic      battle_over;
  logic      calc_en;
  logic      app_en;
  move_idx_t move_sel;
  logic      hit_w;

  battle_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (rng_w)
  );

  assign actr_e   = trainer_e'(actr);
  assign target_e = trainer_e'(target);

  // Once either side is at zero the battle is frozen until reset.
  assign battle_over = (p_hp_q == '0) || (ai_hp_q == '0);
  assign calc_en     = calc_dmg && !battle_over;
  assign app_en      = app_dmg && dmg_valid_q && !battle_over;

  assign move_sel = (actr_e == AI) ? rng_w[5:4] : p_move;
  assign hit_w    = move_hits(move_sel, rng_w[3:0]);

  always_comb begin
    p_hp_d      = p_hp_q;
    ai_hp_d     = ai_hp_q;
    dmg_d       = dmg_q;
    dmg_valid_d = dmg_valid_q;
    last_hit_d  = last_hit_q;
    ai_move_d   = ai_move_q;

    // Apply first so a same-cycle calc still lands on the previously latched damage.
    if (app_en) begin
      if (target_e == AI) begin
        ai_hp_d = hp_sat_sub(ai_hp_q, dmg_q);
      end else begin
        p_hp_d = hp_sat_sub(p_hp_q, dmg_q);
      end
      dmg_valid_d = 1'b0;
    end

    if (calc_en) begin
      dmg_d       = hit_w ? MOVE_DMG[move_sel] : '0;
      last_hit_d  = hit_w;
      dmg_valid_d = 1'b1;
      if (actr_e == AI) begin
        ai_move_d = move_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_hp_q      <= HP_INIT;
      ai_hp_q     <= HP_INIT;
      dmg_q       <= '0;
      dmg_valid_q <= 1'b0;
      last_hit_q  <= 1'b0;
      ai_move_q   <= '0;
    end else begin
      p_hp_q      <= p_hp_d;
      ai_hp_q     <= ai_hp_d;
      dmg_q       <= dmg_d;
      dmg_valid_q <= dmg_valid_d;
      last_hit_q  <= last_hit_d;
      ai_move_q   <= ai_move_d;
    end
  end

  assign p_hp      = p_hp_q;
  assign ai_hp     = ai_hp_q;
  assign dmg       = dmg_q;
  assign dmg_valid = dmg_valid_q;
  assign last_hit  = last_hit_q;
  assign ai_move   = ai_move_q;
  assign rng       = rng_w;

endmodule

// File: tb/tb_battle_datapath.sv
// Self-checking bench for battle_datapath: an LFSR/battle model predicts results,
// calc resolutions go through a scoreboard queue checked one cycle after each calc strobe.
module tb_battle_datapath;

  typedef struct {
    logic [3:0] dmg;
    logic       hit;
    logic       valid;
    logic [1:0] aim;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] p_move;
  logic       actr;
  logic       target;
  logic       calc_dmg;
  logic       app_dmg;
  logic [3:0] p_hp;
  logic [3:0] ai_hp;
  logic [3:0] dmg;
  logic       dmg_valid;
  logic       last_hit;
  logic [1:0] ai_move;
  logic [7:0] rng;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] T_DMG [4] = '{4'd3, 4'd5, 4'd8, 4'd12};
  logic [3:0] T_ACC [4] = '{4'd15, 4'd12, 4'd8, 4'd4};

  logic [7:0] m_rng;
  logic [3:0] e_p_hp, e_ai_hp, e_dmg;
  logic       e_hit, e_valid;
  logic [1:0] e_aim;
  exp_t       sb [$];

  battle_datapath #(
    .MAX_HP    (15),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p_move    (p_move),
    .actr      (actr),
    .target    (target),
    .calc_dmg  (calc_dmg),
    .app_dmg   (app_dmg),
    .p_hp      (p_hp),
    .ai_hp     (ai_hp),
    .dmg       (dmg),
    .dmg_valid (dmg_valid),
    .last_hit  (last_hit),
    .ai_move   (ai_move),
    .rng       (rng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_rng <= 8'hA5;
    else          m_rng <= lfsr_step(m_rng);
  end

  // Scoreboard monitor: every calc strobe pushed one expectation.
  always @(posedge clk) begin
    if (reset_n && calc_dmg) begin
      exp_t e;
      #1;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_empty: calc strobe seen with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (dmg !== e.dmg || last_hit !== e.hit || dmg_valid !== e.valid || ai_move !== e.aim) begin
          tests_failed++;
          $display("FAIL sb_resolve: got dmg=%0d hit=%0b valid=%0b ai_move=%0d, want dmg=%0d hit=%0b valid=%0b ai_move=%0d",
                   dmg, last_hit, dmg_valid, ai_move, e.dmg, e.hit, e.valid, e.aim);
        end
      end
    end
  end

  task automatic model_reset();
    e_p_hp  = 4'd15;
    e_ai_hp = 4'd15;
    e_dmg   = 4'd0;
    e_hit   = 1'b0;
    e_valid = 1'b0;
    e_aim   = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    calc_dmg = 1'b0;
    app_dmg  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive(input logic c, input logic a, input logic [1:0] pm,
                       input logic ac, input logic tg);
    exp_t       e;
    logic [1:0] idx;
    logic       hit;
    @(negedge clk);
    calc_dmg = c;
    app_dmg  = a;
    p_move   = pm;
    actr     = ac;
    target   = tg;
    if (e_p_hp != 4'd0 && e_ai_hp != 4'd0) begin
      if (a && e_valid) begin
        if (tg) e_ai_hp = (e_ai_hp > e_dmg) ? e_ai_hp - e_dmg : 4'd0;
        else    e_p_hp  = (e_p_hp  > e_dmg) ? e_p_hp  - e_dmg : 4'd0;
        e_valid = 1'b0;
      end
      if (c) begin
        idx     = ac ? m_rng[5:4] : pm;
        hit     = (T_ACC[idx] == 4'd15) || (m_rng[3:0] < T_ACC[idx]);
        e_dmg   = hit ? T_DMG[idx] : 4'd0;
        e_hit   = hit;
        e_valid = 1'b1;
        if (ac) e_aim = idx;
      end
    end
    if (c) begin
      e.dmg = e_dmg; e.hit = e_hit; e.valid = e_valid; e.aim = e_aim;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    calc_dmg = 1'b0;
    app_dmg  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (p_hp !== 4'd15 || ai_hp !== 4'd15 || dmg !== 4'd0 || dmg_valid !== 1'b0 ||
        last_hit !== 1'b0 || ai_move !== 2'd0 || rng !== 8'hA5) begin
      tests_failed++;
      $display("FAIL reset_values: got p=%0d ai=%0d dmg=%0d v=%0b hit=%0b aim=%0d rng=%h, want 15 15 0 0 0 0 a5",
               p_hp, ai_hp, dmg, dmg_valid, last_hit, ai_move, rng);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (p_hp !== 4'd15 || ai_hp !== 4'd15 || dmg !== 4'd0 || dmg_valid !== 1'b0 || rng !== m_rng) begin
        tests_failed++;
        $display("FAIL idle_hold[%0d]: got p=%0d ai=%0d dmg=%0d v=%0b rng=%h, want 15 15 0 0 rng=%h",
                 i, p_hp, ai_hp, dmg, dmg_valid, rng, m_rng);
      end
    end
  endtask

  task automatic test_player_hit();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    tests_run++;
    if (dmg !== 4'd3 || last_hit !== 1'b1 || dmg_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL player_calc: got dmg=%0d hit=%0b v=%0b, want 3 1 1", dmg, last_hit, dmg_valid);
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd12 || p_hp !== 4'd15 || dmg_valid !== 1'b0 || dmg !== 4'd3) begin
      tests_failed++;
      $display("FAIL player_apply: got ai=%0d p=%0d v=%0b dmg=%0d, want 12 15 0 3", ai_hp, p_hp, dmg_valid, dmg);
    end
  endtask

  task automatic test_drain_to_zero();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
      tests_run++;
      if (ai_hp !== e_ai_hp) begin
        tests_failed++;
        $display("FAIL drain_round[%0d]: got ai=%0d, want %0d", r, ai_hp, e_ai_hp);
      end
    end
    tests_run++;
    if (ai_hp !== 4'd0) begin
      tests_failed++;
      $display("FAIL drain_zero: got ai=%0d, want 0", ai_hp);
    end
    drive(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd0 || dmg_valid !== 1'b0 || p_hp !== 4'd15) begin
      tests_failed++;
      $display("FAIL battle_lock: got ai=%0d v=%0b p=%0d, want 0 0 15", ai_hp, dmg_valid, p_hp);
    end
  endtask

  task automatic test_ai_miss();
    logic [7:0] nxt;
    bit         found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      nxt = lfsr_step(m_rng);
      if (nxt[5:4] == 2'd3 && nxt[3:0] >= 4'd4) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL ai_search: no rng with move 3 and roll>=4 within 300 cycles, want one");
    end else begin
      drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      tests_run++;
      if (ai_move !== 2'd3 || last_hit !== 1'b0 || dmg !== 4'd0 || dmg_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL ai_miss: got aim=%0d hit=%0b dmg=%0d v=%0b, want 3 0 0 1", ai_move, last_hit, dmg, dmg_valid);
      end
      drive(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      tests_run++;
      if (p_hp !== 4'd15 || dmg_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL ai_miss_apply: got p=%0d v=%0b, want 15 0", p_hp, dmg_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd15 || dmg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL app_noop: got ai=%0d v=%0b, want 15 0", ai_hp, dmg_valid);
    end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd12 || dmg_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle: got ai=%0d v=%0b, want 12 1", ai_hp, dmg_valid);
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tests_run++;
    if (p_hp !== e_p_hp || ai_hp !== 4'd12) begin
      tests_failed++;
      $display("FAIL self_target: got p=%0d ai=%0d, want %0d 12", p_hp, ai_hp, e_p_hp);
    end
    drive(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd9 || dmg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overwrite: got ai=%0d v=%0b, want 9 0", ai_hp, dmg_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    tests_run++;
    if (ai_hp !== 4'd6 || dmg_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_async: got ai=%0d v=%0b, want 6 1", ai_hp, dmg_valid);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (p_hp !== 4'd15 || ai_hp !== 4'd15 || dmg !== 4'd0 || dmg_valid !== 1'b0 ||
        last_hit !== 1'b0 || ai_move !== 2'd0 || rng !== 8'hA5) begin
      tests_failed++;
      $display("FAIL async_reset: got p=%0d ai=%0d dmg=%0d v=%0b hit=%0b aim=%0d rng=%h, want 15 15 0 0 0 0 a5",
               p_hp, ai_hp, dmg, dmg_valid, last_hit, ai_move, rng);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tests_run++;
    if (p_hp !== 4'd12 || ai_hp !== 4'd15) begin
      tests_failed++;
      $display("FAIL post_reset: got p=%0d ai=%0d, want 12 15", p_hp, ai_hp);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    p_move   = 2'd0;
    actr     = 1'b0;
    target   = 1'b0;
    calc_dmg = 1'b0;
    app_dmg  = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_player_hit();
    test_drain_to_zero();
    test_ai_miss();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d queued expectations, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
